// File: rtl/sfft_stream_accum_if.sv
// sfft_stream_accum_if: bundle between the SFFT core, the window accumulator and the readout.
//   en       sample qualifier; only en=1 cycles count toward the window
//   clr      synchronous soft clear (same effect as reset)
//   bit_re   real bitstreams, one bit per lane
//   bit_im   imaginary bitstreams, one bit per lane
//   ready    consumer accepts the frame when ready=1 and valid=1
//   valid    frame in mag_re/mag_im is valid
//   mag_re   per-lane real result, lane k at [k*OW +: OW]
//   mag_im   per-lane imaginary result, same packing
//   overrun  sticky flag: an unaccepted frame was overwritten
//   win_cnt  enabled samples taken in the current window
// Modports: master = environment (core + consumer), slave = accumulator.
interface sfft_stream_accum_if #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned NUMINPUTS = 2
);
  localparam int unsigned OW = BITWIDTH + 1;

  logic                      en;
  logic                      clr;
  logic [NUMINPUTS-1:0]      bit_re;
  logic [NUMINPUTS-1:0]      bit_im;
  logic                      ready;
  logic                      valid;
  logic [NUMINPUTS*OW-1:0]   mag_re;
  logic [NUMINPUTS*OW-1:0]   mag_im;
  logic                      overrun;
  logic [BITWIDTH-1:0]       win_cnt;

  modport master (
    output en, clr, bit_re, bit_im, ready,
    input  valid, mag_re, mag_im, overrun, win_cnt
  );

  modport slave (
    input  en, clr, bit_re, bit_im, ready,
    output valid, mag_re, mag_im, overrun, win_cnt
  );
endinterface

// File: rtl/sfft_stream_accum.sv
// sfft_stream_accum: counts ones on each SFFT output bitstream over a window of 2**BITWIDTH
// enabled cycles and presents one binary magnitude per lane under a valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high, wins over everything
//   bus  sfft_stream_accum_if.slave (en, clr, bit_re, bit_im, ready -> valid, mag_re, mag_im,
//        overrun, win_cnt)
// Build option: define SFFT_ACC_BIPOLAR_EN to emit two's-complement (count - N/2) per lane
// instead of the raw unsigned count. Timing and handshake are identical either way.
module sfft_stream_accum #(
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned NUMINPUTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sfft_stream_accum_if.slave   bus
);
  localparam int unsigned OW   = BITWIDTH + 1;
  localparam int unsigned N    = 1 << BITWIDTH;
  localparam int unsigned HALF = N / 2;
  localparam logic [BITWIDTH-1:0] LAST = BITWIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUMINPUTS-1:0][OW-1:0] acc_re_q, acc_re_d;
  logic [NUMINPUTS-1:0][OW-1:0] acc_im_q, acc_im_d;
  logic [NUMINPUTS-1:0][OW-1:0] res_re_q, res_re_d;
  logic [NUMINPUTS-1:0][OW-1:0] res_im_q, res_im_d;
  logic [BITWIDTH-1:0]          cnt_q, cnt_d;
  logic                         valid_q, valid_d;
  logic                         ovr_q, ovr_d;

  logic                         win_end_c;
  logic [OW-1:0]                sum_re_c;
  logic [OW-1:0]                sum_im_c;

  // Map a raw ones-count to the published lane value.
  function automatic logic [OW-1:0] decode(input logic [OW-1:0] cnt);
`ifdef SFFT_ACC_BIPOLAR_EN
    return cnt - OW'(HALF);
`else
    return cnt;
`endif
  endfunction

  // Last enabled sample of the window; that sample is still counted.
  assign win_end_c = bus.en && (cnt_q == LAST);

  // Next-state, accumulator and frame logic.
  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    sum_re_c = '0;
    sum_im_c = '0;

    if (bus.clr) begin
      state_d  = IDLE;
      acc_re_d = '0;
      acc_im_d = '0;
      res_re_d = '0;
      res_im_d = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      ovr_d    = 1'b0;
    end else begin
      if (bus.en) begin
        // Counter wraps N-1 -> 0 naturally at BITWIDTH bits.
        cnt_d = cnt_q + BITWIDTH'(1);
        for (int unsigned k = 0; k < NUMINPUTS; k++) begin
          sum_re_c = acc_re_q[k] + OW'(bus.bit_re[k]);
          sum_im_c = acc_im_q[k] + OW'(bus.bit_im[k]);
          if (win_end_c) begin
            // Latch totals and restart from zero with no dead cycle.
            res_re_d[k] = decode(sum_re_c);
            res_im_d[k] = decode(sum_im_c);
            acc_re_d[k] = '0;
            acc_im_d[k] = '0;
          end else begin
            acc_re_d[k] = sum_re_c;
            acc_im_d[k] = sum_im_c;
          end
        end
      end

      unique case (state_q)
        IDLE: begin
          if (bus.en) state_d = win_end_c ? PRESENT : ACCUM;
        end
        ACCUM: begin
          if (win_end_c) state_d = PRESENT;
        end
        PRESENT: begin
          // A new frame overwrites; it is only an overrun if the old one was not taken.
          if (win_end_c) begin
            if (!bus.ready) ovr_d = 1'b1;
          end else if (bus.ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = IDLE;
      endcase

      valid_d = (state_d == PRESENT);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_re_q <= '0;
      acc_im_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.mag_re  = res_re_q;
  assign bus.mag_im  = res_im_q;
  assign bus.overrun = ovr_q;
  assign bus.win_cnt = cnt_q;

endmodule

// File: tb/tb_sfft_stream_accum.sv
// tb_sfft_stream_accum: directed bench for sfft_stream_accum at BITWIDTH=4 (N=16), NUMINPUTS=2.
// Expected lane values follow SFFT_ACC_BIPOLAR_EN when it is defined for the build.
module tb_sfft_stream_accum;
  localparam int unsigned BW = 4;
  localparam int unsigned NI = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  sfft_stream_accum_if #(.BITWIDTH(BW), .NUMINPUTS(NI)) bus ();

  sfft_stream_accum #(.BITWIDTH(BW), .NUMINPUTS(NI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ev(input int c);
`ifdef SFFT_ACC_BIPOLAR_EN
    return 5'(c - 8);
`else
    return 5'(c);
`endif
  endfunction

  function automatic logic [31:0] pack2(input int c1, input int c0);
    logic [9:0] v;
    v = {ev(c1), ev(c0)};
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] re, input logic [1:0] im,
                      input logic rdy, input logic cl);
    bus.en     = en;
    bus.bit_re = re;
    bus.bit_im = im;
    bus.ready  = rdy;
    bus.clr    = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int cyc;
    int c;
    logic b;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    check("rst_valid",   32'(bus.valid),   32'd0);
    check("rst_mag_re",  32'(bus.mag_re),  32'd0);
    check("rst_mag_im",  32'(bus.mag_im),  32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_win_cnt", 32'(bus.win_cnt), 32'd0);
    rst = 1'b0;

    // 1: lane0 real all ones for one window.
    for (int i = 0; i < 15; i++) step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    check("t1_valid_early", 32'(bus.valid),   32'd0);
    check("t1_cnt15",       32'(bus.win_cnt), 32'd15);
    step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    check("t1_valid",   32'(bus.valid),   32'd1);
    check("t1_mag_re",  32'(bus.mag_re),  pack2(0, 16));
    check("t1_mag_im",  32'(bus.mag_im),  pack2(0, 0));
    check("t1_cnt_wrap", 32'(bus.win_cnt), 32'd0);
    check("t1_overrun", 32'(bus.overrun), 32'd0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    check("t1_accept", 32'(bus.valid), 32'd0);

    // 2: lane1 alternating, a gap every third cycle (gap bits must be ignored).
    e = 0;
    cyc = 1;
    while (e < 16) begin
      if (cyc % 3 == 0) begin
        step(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
      end else begin
        step(1'b1, {(e % 2 == 0), 1'b0}, 2'b00, 1'b0, 1'b0);
        e++;
      end
      check("t2_win_cnt", 32'(bus.win_cnt), 32'(e % 16));
      if (e < 16) check("t2_valid_early", 32'(bus.valid), 32'd0);
      cyc++;
    end
    check("t2_valid",  32'(bus.valid),  32'd1);
    check("t2_mag_re", 32'(bus.mag_re), pack2(8, 0));
    check("t2_mag_im", 32'(bus.mag_im), pack2(0, 0));
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    check("t2_accept", 32'(bus.valid), 32'd0);

    // 3: two windows without acceptance, then soft clear.
    for (int i = 0; i < 16; i++) step(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    check("t3_valid_a",   32'(bus.valid),   32'd1);
    check("t3_ovr_a",     32'(bus.overrun), 32'd0);
    check("t3_mag_re_a",  32'(bus.mag_re),  pack2(16, 16));
    for (int i = 0; i < 16; i++) step(1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
    check("t3_valid_b",   32'(bus.valid),   32'd1);
    check("t3_ovr_b",     32'(bus.overrun), 32'd1);
    check("t3_mag_re_b",  32'(bus.mag_re),  pack2(0, 0));
    check("t3_mag_im_b",  32'(bus.mag_im),  pack2(0, 16));
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    check("t3_clr_ovr",   32'(bus.overrun), 32'd0);
    check("t3_clr_valid", 32'(bus.valid),   32'd0);
    check("t3_clr_mag",   32'(bus.mag_re),  32'd0);
    check("t3_clr_cnt",   32'(bus.win_cnt), 32'd0);

    // 4: acceptance on the same cycle a window ends.
    for (int i = 0; i < 16; i++) step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    check("t4_mag_re_a", 32'(bus.mag_re), pack2(0, 16));
    for (int i = 0; i < 15; i++) step(1'b1, 2'b10, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b10, 2'b11, 1'b1, 1'b0);
    check("t4_valid",   32'(bus.valid),   32'd1);
    check("t4_mag_re",  32'(bus.mag_re),  pack2(16, 0));
    check("t4_mag_im",  32'(bus.mag_im),  pack2(16, 16));
    check("t4_overrun", 32'(bus.overrun), 32'd0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    check("t4_accept", 32'(bus.valid), 32'd0);

    // 5: abort a partial window by reset and by clear (clear beats en).
    for (int i = 0; i < 7; i++) step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    check("t5_cnt7", 32'(bus.win_cnt), 32'd7);
    rst = 1'b1;
    step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    rst = 1'b0;
    check("t5_rst_valid", 32'(bus.valid),   32'd0);
    check("t5_rst_mag",   32'(bus.mag_re),  32'd0);
    check("t5_rst_ovr",   32'(bus.overrun), 32'd0);
    check("t5_rst_cnt",   32'(bus.win_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    step(1'b1, 2'b11, 2'b11, 1'b0, 1'b1);
    check("t5_clr_cnt", 32'(bus.win_cnt), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    check("t5_valid",  32'(bus.valid),  32'd1);
    check("t5_mag_re", 32'(bus.mag_re), pack2(16, 16));
    check("t5_mag_im", 32'(bus.mag_im), pack2(16, 16));

    // 6: back-to-back windows, consumer always ready.
    for (int s = 0; s < 48; s++) begin
      int w;
      int i;
      w = s / 16;
      i = s % 16;
      if (w == 0)      b = (i % 2 == 1);
      else if (w == 1) b = (i < 5);
      else             b = 1'b1;
      step(1'b1, {1'b0, b}, {~b, 1'b0}, 1'b1, 1'b0);
      check("t6_valid_timing", 32'(bus.valid), 32'(i == 15));
      if (i == 15) begin
        c = (w == 0) ? 8 : ((w == 1) ? 5 : 16);
        check("t6_mag_re", 32'(bus.mag_re), pack2(0, c));
        check("t6_mag_im", 32'(bus.mag_im), pack2(16 - c, 0));
      end
    end
    check("t6_overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
